stream_downsize: RTL and testbench
==================================

# stream_downsize

Width-reducing stream converter: accepts one wide word of `T_DATA_RATIO` lanes with per-lane keep and emits the kept lanes one at a time on a narrow `T_DATA_WIDTH` stream. It is the transmit-side counterpart of the stream upsizer. It sits between a wide producer and a narrow consumer, so `stream_upsize` → `stream_downsize` round-trips a packet. Ready/valid handshakes are used on both sides. Packet boundaries are carried by `last`.

## Interface
Parameters:
- `T_DATA_WIDTH`, 4: width of one lane / one narrow beat.
- `T_DATA_RATIO`, 2: lanes per wide word; must be ≥ 2.

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `s_data_i` input `[T_DATA_WIDTH-1:0]` × `[T_DATA_RATIO-1:0]` (unpacked): wide word; lane i = `s_data_i[i]`.
- `s_keep_i` input `T_DATA_RATIO`: bit i=1 → lane i carries data.
- `s_last_i` input 1: wide word ends a packet.
- `s_valid_i` input 1: wide word valid.
- `s_ready_o` output 1: block can accept a wide word.
- `m_data_o` output `T_DATA_WIDTH`: narrow beat data.
- `m_last_o` output 1: narrow beat ends the packet.
- `m_valid_o` output 1: narrow beat valid.
- `m_ready_i` input 1: consumer accepts the beat.

## Operation
- Internal state:
  - a holding register for one wide word (data, last);
  - a `pending` mask of kept lanes not yet sent;
  - FSM {IDLE, SEND}.
- IDLE: `s_ready_o`=1 and `m_valid_o`=0. On s-handshake:
  - if `s_keep_i`≠0: load the holding register, set `pending`=`s_keep_i`, go to SEND.
  - if `s_keep_i`=0: the word is accepted and discarded with no output, even when `s_last_i`=1. Stay in IDLE.
- SEND: `m_valid_o`=1.
  - Current lane = lowest set bit of `pending` (priority encoder, ascending index).
  - `m_data_o` = held lane data.
  - `m_last_o` = held last AND current lane is the only bit left in `pending`.
- On m-handshake in SEND:
  - clear the current lane bit in `pending`.
  - if that was the final pending bit, the beat is "final".
- Final beat:
  - `s_ready_o`=1 in the same cycle (combinational: `state==SEND && final && m_ready_i`).
  - if an s-handshake also occurs, load the new word and stay in SEND (keep≠0) or go to IDLE (keep=0).
  - otherwise go to IDLE.
- Non-final beats in SEND: `s_ready_o`=0.
- Sparse keep is legal: lanes with keep=0 are skipped, never emitted, and cost no cycles.
  - Example: keep=4'b1010 emits lane1, then lane3.
- `m_data_o`, `m_last_o` and `m_valid_o` hold stable while `m_valid_o`=1 and `m_ready_i`=0.
- `s_data_i`/`s_keep_i`/`s_last_i` are sampled only on s-handshake. Values outside a handshake are ignored.

## Timing
- Reset (`rst`=1, asynchronous):
  - FSM=IDLE, `pending`=0, holding register=0.
  - `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0.
  - `s_ready_o` is forced to 0 while `rst`=1, and is 1 from the first cycle after deassertion.
- Latency: a word accepted at edge N presents its first kept lane with `m_valid_o`=1 after edge N (registered; no comb path s→m data).
- Throughput:
  - one narrow beat per cycle while `m_ready_i`=1.
  - a wide word with k kept lanes occupies exactly k cycles.
  - back-to-back words have zero bubbles thanks to same-cycle reload on the final beat.
- `s_ready_o` depends combinationally on `m_ready_i` (final beat only). No other comb input→output paths.
- Reset mid-packet discards the held word and its pending lanes. No `m_last_o` is emitted for it.
- Backpressure on the final beat (`m_ready_i`=0) keeps `s_ready_o`=0. No new word is accepted until that beat completes.

## Test plan
- Reset check (RATIO=2, WIDTH=4): assert `rst` asynchronously mid-cycle → `m_valid_o`/`m_last_o`/`m_data_o`=0 immediately and `s_ready_o`=0. After release, `s_ready_o`=1.
- Full word, no backpressure: data {L1=4'hB, L0=4'hA}, keep=2'b11, last=1, `m_ready_i`=1 → beats A (last=0), then B (last=1) on consecutive cycles. `s_ready_o`=1 in B's cycle.
- Sparse keep (RATIO=4): data {D,C,B,A}, keep=4'b1010, last=1 → beats B (last=0), D (last=1). Two cycles total. A and C are never emitted.
- Back-to-back plus backpressure: words {2,1} keep 11 last 0, then {4,3} keep 11 last 1. Hold `m_ready_i`=0 for 2 cycles on beat 2 → stream 1,2,3,4 with no bubble between 2 and 3. `m_data_o`=2 is stable during the stall. `m_last_o` appears only on 4.
- Keep=0 word: keep=0, last=1 accepted in IDLE → no `m_valid_o`. The next word keep=01, data L0=4'h7, last=1 → single beat 7 with `m_last_o`=1.
- Reset during SEND after the first of 4 kept lanes → no further beats. After release, a fresh word is emitted correctly starting from its lowest kept lane.

Source files
------------

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each accepted wide word
// one per cycle, lowest lane first, with same-cycle reload on the final beat.
module stream_downsize #(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IDX_W = $clog2(T_DATA_RATIO);

  typedef enum logic {IDLE, SEND} state_t;

  // Index of the lowest set bit (ascending priority).
  function automatic logic [IDX_W-1:0] f_low_idx(input logic [T_DATA_RATIO-1:0] p);
    f_low_idx = '0;
    for (int i = int'(T_DATA_RATIO) - 1; i >= 0; i--) begin
      if (p[i]) f_low_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic f_single(input logic [T_DATA_RATIO-1:0] p);
    f_single = (p != '0) && ((p & (p - T_DATA_RATIO'(1))) == '0);
  endfunction

  state_t                  r_state;
  logic [T_DATA_WIDTH-1:0] r_data [T_DATA_RATIO];
  logic                    r_last;
  logic [T_DATA_RATIO-1:0] r_pending;
  logic [T_DATA_WIDTH-1:0] r_m_data;
  logic                    r_m_last;
  logic                    r_m_valid;

  state_t                  w_state_nxt;
  logic [T_DATA_WIDTH-1:0] w_data_nxt [T_DATA_RATIO];
  logic                    w_last_nxt;
  logic [T_DATA_RATIO-1:0] w_pending_nxt;
  logic [T_DATA_RATIO-1:0] w_cur_onehot;
  logic                    w_final;
  logic                    w_s_hs;
  logic                    w_load;

  assign w_cur_onehot = r_pending & (~r_pending + T_DATA_RATIO'(1));
  assign w_final      = (r_state == SEND) && f_single(r_pending);
  // Ready in IDLE, or on a completing final beat so the next word reloads without a bubble.
  assign s_ready_o    = !rst && ((r_state == IDLE) || (w_final && m_ready_i));
  assign w_s_hs       = s_valid_i && s_ready_o;
  assign w_load       = w_s_hs && (s_keep_i != '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_data_nxt    = r_data;
    w_last_nxt    = r_last;
    if (r_state == SEND && m_ready_i) begin
      w_pending_nxt = r_pending & ~w_cur_onehot;
      if (w_final) w_state_nxt = IDLE;
    end
    // A keep=0 word is swallowed: no load, state follows the branch above.
    if (w_load) begin
      w_state_nxt   = SEND;
      w_pending_nxt = s_keep_i;
      w_data_nxt    = s_data_i;
      w_last_nxt    = s_last_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_last    <= 1'b0;
      for (int i = 0; i < int'(T_DATA_RATIO); i++) r_data[i] <= '0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_last    <= w_last_nxt;
      r_data    <= w_data_nxt;
      r_m_valid <= (w_state_nxt == SEND);
      r_m_data  <= (w_state_nxt == SEND) ? w_data_nxt[f_low_idx(w_pending_nxt)] : '0;
      r_m_last  <= (w_state_nxt == SEND) && w_last_nxt && f_single(w_pending_nxt);
    end
  end

  assign m_data_o  = r_m_data;
  assign m_last_o  = r_m_last;
  assign m_valid_o = r_m_valid;

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize (4 lanes of 4 bits); outputs checked on the falling edge.
module tb_stream_downsize;

  localparam int unsigned W = 4;
  localparam int unsigned R = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] s_data [R];
  logic [R-1:0] s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [W-1:0] d, input logic l);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_data"},  32'(m_data),  32'(d));
    chk({tag, "_last"},  32'(m_last),  32'(l));
  endtask

  task automatic drive(input logic [W-1:0] d3, input logic [W-1:0] d2, input logic [W-1:0] d1,
                       input logic [W-1:0] d0, input logic [R-1:0] k, input logic l);
    s_data[3] = d3; s_data[2] = d2; s_data[1] = d1; s_data[0] = d0;
    s_keep = k; s_last = l; s_valid = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < int'(R); i++) s_data[i] = '0;

    // Reset state
    nxt(); nxt();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data",  32'(m_data),  32'd0);
    chk("rst_last",  32'(m_last),  32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(s_ready), 32'd1);

    // Full word, no backpressure
    nxt();
    m_ready = 1'b1;
    drive(4'h0, 4'h0, 4'hB, 4'hA, 4'b0011, 1'b1);
    nxt();
    beat("full_b0", 4'hA, 1'b0);
    chk("full_b0_sready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    nxt();
    beat("full_b1", 4'hB, 1'b1);
    chk("full_b1_sready", 32'(s_ready), 32'd1);
    nxt();
    chk("full_idle", 32'(m_valid), 32'd0);

    // Sparse keep 1010
    drive(4'hD, 4'hC, 4'hB, 4'hA, 4'b1010, 1'b1);
    nxt();
    beat("sparse_b0", 4'hB, 1'b0);
    s_valid = 1'b0;
    nxt();
    beat("sparse_b1", 4'hD, 1'b1);
    nxt();
    chk("sparse_idle", 32'(m_valid), 32'd0);

    // Back-to-back with a two-cycle stall on beat 2
    drive(4'h0, 4'h0, 4'h2, 4'h1, 4'b0011, 1'b0);
    nxt();
    beat("b2b_1", 4'h1, 1'b0);
    chk("b2b_1_sready", 32'(s_ready), 32'd0);
    drive(4'h0, 4'h0, 4'h4, 4'h3, 4'b0011, 1'b1);
    nxt();
    m_ready = 1'b0;
    #1 beat("b2b_2a", 4'h2, 1'b0);
    chk("b2b_stall_sready_a", 32'(s_ready), 32'd0);
    nxt();
    beat("b2b_2b", 4'h2, 1'b0);
    chk("b2b_stall_sready_b", 32'(s_ready), 32'd0);
    nxt();
    beat("b2b_2c", 4'h2, 1'b0);
    m_ready = 1'b1;
    #1 chk("b2b_final_sready", 32'(s_ready), 32'd1);
    nxt();
    beat("b2b_3", 4'h3, 1'b0);
    s_valid = 1'b0;
    nxt();
    beat("b2b_4", 4'h4, 1'b1);
    nxt();
    chk("b2b_idle", 32'(m_valid), 32'd0);

    // keep=0 word is discarded, then a single-lane word
    drive(4'hF, 4'hF, 4'hF, 4'hF, 4'b0000, 1'b1);
    nxt();
    chk("k0_valid", 32'(m_valid), 32'd0);
    chk("k0_sready", 32'(s_ready), 32'd1);
    drive(4'h0, 4'h0, 4'h0, 4'h7, 4'b0001, 1'b1);
    nxt();
    beat("k1_b0", 4'h7, 1'b1);
    s_valid = 1'b0;
    nxt();
    chk("k1_idle", 32'(m_valid), 32'd0);

    // Asynchronous reset mid-packet
    drive(4'h4, 4'h3, 4'h2, 4'h1, 4'b1111, 1'b1);
    nxt();
    beat("mid_b0", 4'h1, 1'b0);
    s_valid = 1'b0;
    nxt();
    beat("mid_b1", 4'h2, 1'b0);
    #2 rst = 1'b1;
    #1 chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data",  32'(m_data),  32'd0);
    chk("mid_rst_last",  32'(m_last),  32'd0);
    chk("mid_rst_sready", 32'(s_ready), 32'd0);
    nxt();
    chk("mid_rst_hold", 32'(m_valid), 32'd0);
    rst = 1'b0;
    #1 chk("mid_rel_sready", 32'(s_ready), 32'd1);
    drive(4'h0, 4'h6, 4'h5, 4'h0, 4'b0110, 1'b1);
    nxt();
    beat("fresh_b0", 4'h5, 1'b0);
    s_valid = 1'b0;
    nxt();
    beat("fresh_b1", 4'h6, 1'b1);
    nxt();
    chk("fresh_idle", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
